// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a pending-flush latch.
// Define PIPE_STAGE_PERF_CNT_EN to add saturating bubble/flush performance counters.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W     = 160,
    parameter int unsigned       RADDR_W    = 5,
    parameter int unsigned       STALL_W    = 6,
    parameter int unsigned       STAGE_IDX  = 2,
    parameter int unsigned       N_FLUSH    = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [STALL_W-1:0] stall_i,
    input  logic [N_FLUSH-1:0] flush_i,
    input  logic               valid_i,
    input  logic [DATA_W-1:0]  payload_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic               is_load_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  payload_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic               is_load_o,
`ifdef PIPE_STAGE_PERF_CNT_EN
    output logic               flush_pending_o,
    input  logic               perf_clr_i,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
`else
    output logic               flush_pending_o
`endif
);

    logic               cur, nxt, fl;
    logic               valid_d, is_load_d, pending_d, flush_fire;
    logic [DATA_W-1:0]  payload_d;
    logic [RADDR_W-1:0] rd_d;
    logic               unused_stall;

    assign cur          = stall_i[STAGE_IDX];
    assign nxt          = stall_i[STAGE_IDX+1];
    assign fl           = |flush_i;
    assign unused_stall = ^stall_i;

    // Rule priority: hold, stall-bubble, flush (incl. latched pending), load.
    always_comb begin
        valid_d    = valid_o;
        payload_d  = payload_o;
        rd_d       = rd_o;
        is_load_d  = is_load_o;
        pending_d  = flush_pending_o;
        flush_fire = 1'b0;
        if (cur && nxt) begin
            if (fl) pending_d = 1'b1;
        end else if (cur || fl || flush_pending_o || !valid_i) begin
            valid_d    = 1'b0;
            payload_d  = BUBBLE_VAL;
            rd_d       = '0;
            is_load_d  = 1'b0;
            pending_d  = 1'b0;
            flush_fire = !cur && (fl || flush_pending_o);
        end else begin
            valid_d   = 1'b1;
            payload_d = payload_i;
            rd_d      = rd_i;
            is_load_d = is_load_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o         <= 1'b0;
            payload_o       <= BUBBLE_VAL;
            rd_o            <= '0;
            is_load_o       <= 1'b0;
            flush_pending_o <= 1'b0;
        end else begin
            valid_o         <= valid_d;
            payload_o       <= payload_d;
            rd_o            <= rd_d;
            is_load_o       <= is_load_d;
            flush_pending_o <= pending_d;
        end
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Bubble count follows the post-edge valid; both counters saturate, clear wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else if (perf_clr_i) begin
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            if (!valid_d && !(&bubble_cnt_o)) bubble_cnt_o <= bubble_cnt_o + 1'b1;
            if (flush_fire && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    logic             unused_fire;
    assign unused_cnt_w = '0;
    assign unused_fire  = flush_fire;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// checked against a slot-level reference model.
module tb_pipe_stage_reg;

    localparam int unsigned       DATA_W    = 32;
    localparam int unsigned       RADDR_W   = 5;
    localparam int unsigned       STALL_W   = 6;
    localparam int unsigned       STAGE_IDX = 2;
    localparam int unsigned       N_FLUSH   = 2;
    localparam logic [DATA_W-1:0] BUBBLE    = 32'hDEAD_0013;
    localparam int unsigned       CNT_W     = 4;
    localparam int                CNT_MAX   = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [STALL_W-1:0] stall = '0;
    logic [N_FLUSH-1:0] flush = '0;
    logic               valid_in = 1'b0;
    logic [DATA_W-1:0]  payload_in = '0;
    logic [RADDR_W-1:0] rd_in = '0;
    logic               load_in = 1'b0;
    logic               perf_clr = 1'b0;
    logic               valid_out, load_out, pend_out;
    logic [DATA_W-1:0]  payload_out;
    logic [RADDR_W-1:0] rd_out;
    logic [CNT_W-1:0]   bubble_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: contents of the slot plus latched flush and counters.
    logic               exp_valid, exp_load, exp_pend;
    logic [DATA_W-1:0]  exp_payload;
    logic [RADDR_W-1:0] exp_rd;
    int                 exp_bcnt, exp_fcnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .RADDR_W(RADDR_W), .STALL_W(STALL_W), .STAGE_IDX(STAGE_IDX),
        .N_FLUSH(N_FLUSH), .BUBBLE_VAL(BUBBLE), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .flush_i(flush),
        .valid_i(valid_in), .payload_i(payload_in), .rd_i(rd_in), .is_load_i(load_in),
        .valid_o(valid_out), .payload_o(payload_out), .rd_o(rd_out), .is_load_o(load_out),
        .flush_pending_o(pend_out)
`ifdef PIPE_STAGE_PERF_CNT_EN
        , .perf_clr_i(perf_clr), .bubble_cnt_o(bubble_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

`ifndef PIPE_STAGE_PERF_CNT_EN
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

    always @(posedge clk) begin
        if (rst_n)
            assert (!(!stall[STAGE_IDX] && stall[STAGE_IDX+1]))
                else $error("[TB] illegal stall vector %b", stall);
    end

    task automatic model_reset();
        exp_valid = 1'b0; exp_payload = BUBBLE; exp_rd = '0; exp_load = 1'b0;
        exp_pend = 1'b0; exp_bcnt = 0; exp_fcnt = 0;
    endtask

    task automatic model_empty();
        exp_valid = 1'b0; exp_payload = BUBBLE; exp_rd = '0; exp_load = 1'b0;
    endtask

    // Advance one clock; the model decides where the slot goes from the sampled inputs.
    task automatic step();
        bit stopped, downstream_stopped, kill, fired;
        stopped            = stall[STAGE_IDX];
        downstream_stopped = stall[STAGE_IDX+1];
        kill               = (flush != 0);
        fired              = 0;
        @(posedge clk);
        if (rst_n) begin
            if (stopped && downstream_stopped) begin
                exp_pend = exp_pend | kill;
            end else if (stopped) begin
                model_empty();
                exp_pend = 1'b0;
            end else if (kill || exp_pend) begin
                model_empty();
                exp_pend = 1'b0;
                fired    = 1;
            end else if (valid_in) begin
                exp_valid = 1'b1; exp_payload = payload_in; exp_rd = rd_in; exp_load = load_in;
            end else begin
                model_empty();
            end
            if (perf_clr) begin
                exp_bcnt = 0; exp_fcnt = 0;
            end else begin
                if (!exp_valid) exp_bcnt = (exp_bcnt < CNT_MAX) ? exp_bcnt + 1 : CNT_MAX;
                if (fired)      exp_fcnt = (exp_fcnt < CNT_MAX) ? exp_fcnt + 1 : CNT_MAX;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] p, input logic [RADDR_W-1:0] r,
                         input logic l);
        valid_in = v; payload_in = p; rd_in = r; load_in = l;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if ({valid_out, payload_out, rd_out, load_out, pend_out} !== {1'b0, BUBBLE, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b p=%h rd=%0d l=%b pend=%b, want bubble", valid_out, payload_out, rd_out, load_out, pend_out);
        end
        rst_n = 1'b1;
        drive(1'b1, 32'h33, 5'd3, 1'b0);
        step();
        stall = 6'b001100; flush = 2'b01;
        step();
        flush = 2'b00;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({valid_out, payload_out, rd_out, pend_out} !== {1'b0, BUBBLE, 5'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b p=%h rd=%0d pend=%b, want bubble/no pending", valid_out, payload_out, rd_out, pend_out);
        end
        #2 rst_n = 1'b1;
        step();
        checks++;
        if ({valid_out, payload_out, pend_out} !== {1'b0, BUBBLE, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_release_hold: got v=%b p=%h pend=%b, want held bubble", valid_out, payload_out, pend_out);
        end
        stall = '0;
    endtask

    task automatic test_load();
        drive(1'b1, 32'hA5, 5'd7, 1'b1);
        step();
        checks++;
        if ({valid_out, payload_out, rd_out, load_out} !== {1'b1, 32'hA5, 5'd7, 1'b1}) begin
            errors++;
            $display("[TB] FAIL load: got v=%b p=%h rd=%0d l=%b, want 1 a5 7 1", valid_out, payload_out, rd_out, load_out);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 32'h11, 5'd4, 1'b0);
        step();
        stall = 6'b001100;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + i, 5'd9, 1'b1);
            step();
            checks++;
            if ({valid_out, payload_out, rd_out} !== {1'b1, 32'h11, 5'd4}) begin
                errors++;
                $display("[TB] FAIL hold_%0d: got v=%b p=%h rd=%0d, want 1 11 4", i, valid_out, payload_out, rd_out);
            end
        end
    endtask

    task automatic test_stall_bubble();
        stall = 6'b000100;
        drive(1'b1, 32'h77, 5'd12, 1'b1);
        step();
        checks++;
        if ({valid_out, payload_out, rd_out, load_out} !== {1'b0, BUBBLE, 5'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_bubble: got v=%b p=%h rd=%0d l=%b, want bubble", valid_out, payload_out, rd_out, load_out);
        end
        stall = '0;
    endtask

    task automatic test_pending_flush();
        int fcnt_before;
        drive(1'b1, 32'h22, 5'd5, 1'b0);
        step();
        stall = 6'b001100; flush = 2'b10;
        step();
        flush = 2'b00;
        checks++;
        if ({pend_out, payload_out} !== {1'b1, 32'h22}) begin
            errors++;
            $display("[TB] FAIL pending_set: got pend=%b p=%h, want 1 22", pend_out, payload_out);
        end
        step();
        checks++;
        if (pend_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pending_kept: got pend=%b, want 1", pend_out);
        end
        fcnt_before = exp_fcnt;
        stall = '0;
        drive(1'b1, 32'h44, 5'd6, 1'b0);
        step();
        checks++;
        if ({valid_out, payload_out, pend_out} !== {1'b0, BUBBLE, 1'b0}) begin
            errors++;
            $display("[TB] FAIL pending_applied: got v=%b p=%h pend=%b, want bubble no pending", valid_out, payload_out, pend_out);
        end
`ifdef PIPE_STAGE_PERF_CNT_EN
        checks++;
        if (int'(flush_cnt) !== fcnt_before + 1) begin
            errors++;
            $display("[TB] FAIL pending_flush_cnt: got %0d, want %0d", flush_cnt, fcnt_before + 1);
        end
`endif
        stall = 6'b000100; flush = 2'b01;
        step();
        flush = 2'b00; stall = '0;
        checks++;
        if ({valid_out, pend_out} !== {1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL flush_absorbed: got v=%b pend=%b, want 0 0", valid_out, pend_out);
        end
        step();
        checks++;
        if ({valid_out, payload_out} !== {1'b1, 32'h44}) begin
            errors++;
            $display("[TB] FAIL after_absorb_load: got v=%b p=%h, want 1 44", valid_out, payload_out);
        end
    endtask

    task automatic test_simul_flush();
        int fcnt_before;
        fcnt_before = exp_fcnt;
        drive(1'b1, 32'h99, 5'd8, 1'b1);
        flush = 2'b11;
        step();
        flush = 2'b00;
        checks++;
        if ({valid_out, payload_out, rd_out, load_out} !== {1'b0, BUBBLE, 5'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL simul_flush: got v=%b p=%h rd=%0d l=%b, want bubble", valid_out, payload_out, rd_out, load_out);
        end
`ifdef PIPE_STAGE_PERF_CNT_EN
        checks++;
        if (int'(flush_cnt) !== fcnt_before + 1) begin
            errors++;
            $display("[TB] FAIL simul_flush_cnt: got %0d, want %0d", flush_cnt, fcnt_before + 1);
        end
`endif
    endtask

    task automatic test_saturation();
`ifdef PIPE_STAGE_PERF_CNT_EN
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bubble_cnt !== 4'd15) begin
            errors++;
            $display("[TB] FAIL bubble_saturate: got %0d, want 15", bubble_cnt);
        end
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        checks++;
        if ({bubble_cnt, flush_cnt} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL perf_clear: got b=%0d f=%0d, want 0 0", bubble_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1: stall = 6'($urandom) & ~6'b001100;
                2:    stall = 6'($urandom) | 6'b001100;
                default: stall = (6'($urandom) & ~6'b001000) | 6'b000100;
            endcase
            flush    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            perf_clr = ($urandom_range(0, 30) == 0);
            drive(1'($urandom), 32'($urandom), 5'($urandom), 1'($urandom));
            step();
            checks++;
            if ({valid_out, payload_out, rd_out, load_out, pend_out} !==
                {exp_valid, exp_payload, exp_rd, exp_load, exp_pend}) begin
                errors++;
                $display("[TB] FAIL random_%0d: got v=%b p=%h rd=%0d l=%b pend=%b, want v=%b p=%h rd=%0d l=%b pend=%b",
                         i, valid_out, payload_out, rd_out, load_out, pend_out,
                         exp_valid, exp_payload, exp_rd, exp_load, exp_pend);
            end
`ifdef PIPE_STAGE_PERF_CNT_EN
            checks++;
            if (int'(bubble_cnt) !== exp_bcnt || int'(flush_cnt) !== exp_fcnt) begin
                errors++;
                $display("[TB] FAIL random_cnt_%0d: got b=%0d f=%0d, want b=%0d f=%0d",
                         i, bubble_cnt, flush_cnt, exp_bcnt, exp_fcnt);
            end
`endif
        end
        stall = '0; flush = '0; perf_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_hold();
        test_stall_bubble();
        test_pending_flush();
        test_simul_flush();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. Successor to the fixed-width ID/EX register; intended for every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload plus valid, destination-register tag and load flag. These feed hazard detection in the upstream stage.
- Adds three things over the old register:
  - a flush-source vector of any width,
  - a pending-flush latch, so a flush that arrives during a hold is not lost,
  - optional performance counters.

Parameters:
- DATA_W, 160: payload width in bits (e.g. op1, op2, inst, inst_addr, we, waddr).
- RADDR_W, 5: destination register tag width.
- STALL_W, 6: width of the global stall vector.
- STAGE_IDX, 2: index of this stage in the stall vector. Legal range 0..STALL_W-2.
- N_FLUSH, 2: number of flush sources (e.g. jump, interrupt).
- BUBBLE_VAL, {DATA_W{1'b0}}: payload value driven for a bubble (NOP encoding is supplied by the instantiator).
- CNT_W, 16: performance counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- stall_i  in  STALL_W  global stall vector; 1 = stop.
- flush_i  in  N_FLUSH  flush requests; any bit set = flush.
- valid_i  in  1  upstream slot holds a real instruction.
- payload_i  in  DATA_W  upstream payload.
- rd_i  in  RADDR_W  upstream destination register.
- is_load_i  in  1  upstream instruction is a load.
- valid_o  out  1  registered valid.
- payload_o  out  DATA_W  registered payload.
- rd_o  out  RADDR_W  registered destination register (to hazard unit).
- is_load_o  out  1  registered load flag (to hazard unit).
- flush_pending_o  out  1  a flush was received during hold and is not yet applied.
- perf_clr_i  in  1  synchronous counter clear (present only with PERF_CNT_EN).
- bubble_cnt_o  out  CNT_W  bubble cycles (present only with PERF_CNT_EN).
- flush_cnt_o  out  CNT_W  applied flushes (present only with PERF_CNT_EN).

Behaviour:
- Definitions:
  - cur = stall_i[STAGE_IDX]
  - nxt = stall_i[STAGE_IDX+1]
  - fl = |flush_i
  - "bubble" means: valid_o=0, payload_o=BUBBLE_VAL, rd_o=0, is_load_o=0.
- Reset (rst_n_i low, asynchronous): bubble, flush_pending_o=0, counters=0. Reset released mid-hold restarts from the bubble state; no state survives.
- Per rising edge, first matching rule wins:
  1. HOLD (cur=1, nxt=1): all data outputs keep their value. If fl, set pending=1; otherwise pending keeps its value.
  2. STALL-BUBBLE (cur=1, nxt=0): drive bubble; pending=0, because the held slot has left the stage.
  3. FLUSH (fl=1 or pending=1): drive bubble; pending=0.
  4. LOAD: valid_o<=valid_i.
     - If valid_i=1: payload_o<=payload_i, rd_o<=rd_i, is_load_o<=is_load_i.
     - If valid_i=0: drive bubble.
- Latency is one cycle from input to output. There is no combinational path from inputs to outputs.
- cur=0 with nxt=1 is illegal (stall vectors are monotone toward the front of the pipe). This case falls through to the FLUSH/LOAD rules; the bench flags it with an assertion.
- fl during STALL-BUBBLE is absorbed, because the stage is already emptied. Pending is not set.
- Multiple flush bits in the same cycle count as one flush event.
- flush_pending_o is the registered pending bit.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- When defined:
  - bubble_cnt_o increments each cycle in which valid_o=0 after the edge.
  - flush_cnt_o increments each time rule 3 fires.
  - Both saturate at all-ones.
  - perf_clr_i=1 zeroes both on the next edge. Clear beats increment.
- When undefined: perf_clr_i, bubble_cnt_o and flush_cnt_o are absent, and no counter flops are built.

Test Plan:
- Reset then load: rst_n_i low mid-cycle clears outputs immediately. Then valid_i=1, payload_i=0xA5, rd_i=7, is_load_i=1, stall=0 -> next edge valid_o=1, payload_o=0xA5, rd_o=7, is_load_o=1.
- Hold: payload 0x11 loaded, then stall_i=6'b001100 for 3 cycles while payload_i changes -> payload_o stays 0x11 throughout.
- Stall-bubble: stall_i=6'b000100 -> next edge valid_o=0, payload_o=BUBBLE_VAL, rd_o=0; upstream payload not captured.
- Pending flush: hold active, flush_i=2'b10 for 1 cycle -> flush_pending_o=1, payload held. Release stall with flush_i=0 -> one bubble, flush_pending_o=0, flush_cnt_o=1 (with PERF_CNT_EN).
- Simultaneous flush: flush_i=2'b11, no stall -> bubble, flush_cnt_o increments by exactly 1.
- Counter saturation with CNT_W=4: 20 consecutive bubble cycles -> bubble_cnt_o=15. Then perf_clr_i=1 -> 0 on next edge.
